// File: rtl/receiver_fifo.sv
// UART 8N1 receiver feeding a show-ahead byte FIFO.
// Reports framing errors with a one-cycle pulse and dropped bytes with a sticky flag.
module receiver_fifo #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     RsRx,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     frame_err,
  output logic                     overflow
);

  localparam int unsigned PW           = $clog2(DEPTH);
  localparam int unsigned CW           = PW + 1;
  localparam int unsigned TICK_DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int unsigned TICK_DIV     = (TICK_DIV_RAW == 0) ? 1 : TICK_DIV_RAW;
  localparam int unsigned DW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_sync_q;
  logic [DW-1:0]   div_q, div_d;
  logic [3:0]      tick_cnt_q, tick_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            push_q, push_d;
  logic            frame_err_q, frame_err_d;
  logic            tick_c;

  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            empty_q, empty_d;
  logic            full_q, full_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            pop_c, push_ok_c, drop_c, full_now_c;

  assign tick_c = (div_q == DW'(TICK_DIV - 1));

  // Receive FSM, oversampling counters and tick divider
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    div_d       = tick_c ? '0 : div_q + DW'(1);
    case (state_q)
      IDLE: begin
        if (!rx_sync_q) begin
          state_d    = START;
          div_d      = '0;
          tick_cnt_d = '0;
        end
      end
      START: begin
        if (tick_c) begin
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_sync_q ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick_c) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            shift_d   = {rx_sync_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick_c) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            if (rx_sync_q) begin
              push_d  = 1'b1;
              state_d = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = BREAK;
            end
          end
        end
      end
      BREAK: begin
        if (rx_sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping; a push into a full FIFO only lands if a pop frees a slot
  always_comb begin
    full_now_c = (count_q == CW'(DEPTH));
    pop_c      = rd_en && (count_q != '0);
    push_ok_c  = push_q && (!full_now_c || pop_c);
    drop_c     = push_q && full_now_c && !pop_c;
    wr_ptr_d   = push_ok_c ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop_c ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push_ok_c && !pop_c) count_d = count_q + CW'(1);
    else if (!push_ok_c && pop_c) count_d = count_q - CW'(1);
    empty_d    = (count_d == '0);
    full_d     = (count_d == CW'(DEPTH));
    overflow_d = drop_c || (overflow_q && !clr_err);
    // Next head bypasses the array when it is the byte being written this cycle
    if (count_d == '0) rd_data_d = 8'h00;
    else if (push_ok_c && (wr_ptr_q == rd_ptr_d)) rd_data_d = shift_q;
    else rd_data_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= IDLE;
      div_q       <= '0;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      rd_data_q   <= 8'h00;
    end else begin
      rx_meta_q   <= RsRx;
      rx_sync_q   <= rx_meta_q;
      state_q     <= state_d;
      div_q       <= div_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Storage array carries no reset; contents are meaningless until written
  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rd_data   = rd_data_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule
